// File: rtl/druaga_sprite_shadow.sv
// ---------------------------------------------------------------------------
// druaga_sprite_shadow
//
// Double-buffered sprite attribute shadow placed in front of the sprite line
// renderer. On each rising edge of VBLK it reads all 64 sprites x 2 attribute
// words (128 entries) from the three CPU-side 8-bit sprite RAM banks and
// assembles them into 24-bit words. The words go into the hidden (back) half
// of a 2 x 128 x 24-bit buffer. When the copy is complete the halves swap,
// so the renderer only ever sees a complete, frame-coherent snapshot.
//
// Ports
//   VCLKx4  in   1   single clock, rising edge
//   RESET   in   1   asynchronous, active-high reset
//   VBLK    in   1   vertical blank level (already synchronous to VCLKx4)
//   FREEZE  in   1   sampled at the trigger; when high, that frame is skipped
//   SRC_A   out  9   source address {bank[1:0], index[6:0]}
//   SRC_RD  out  1   source read strobe, high whenever SRC_A is valid
//   SRC_D   in   8   source data, valid one cycle after the SRC_RD cycle
//   SPRA_A  in   7   renderer address {sprite[5:0], word}
//   SPRA_D  out  24  {byte2, byte1, byte0} read combinationally from the front half
//   BUSY    out  1   high while a copy is in progress
//   DONE    out  1   one-cycle pulse in the swap cycle
//   FRONT   out  1   index of the half currently shown to the renderer
// ---------------------------------------------------------------------------
module druaga_sprite_shadow (
    input  logic        VCLKx4,
    input  logic        RESET,
    input  logic        VBLK,
    input  logic        FREEZE,
    output logic [8:0]  SRC_A,
    output logic        SRC_RD,
    input  logic [7:0]  SRC_D,
    input  logic [6:0]  SPRA_A,
    output logic [23:0] SPRA_D,
    output logic        BUSY,
    output logic        DONE,
    output logic        FRONT
);

    // Copy sequencer: three source reads per entry, then one write cycle.
    typedef enum logic [2:0] {
        S_IDLE,
        S_RD0,
        S_RD1,
        S_RD2,
        S_WR,
        S_SWAP
    } state_t;

    state_t       state;
    state_t       state_nx;
    logic [6:0]   idx;
    logic [6:0]   idx_nx;
    logic         front;
    logic         front_nx;
    logic [7:0]   b0;
    logic [7:0]   b1;
    logic         vblk_d;
    logic         armed;
    logic         trigger;
    logic         wr_en;
    logic [7:0]   wr_addr;
    logic [23:0]  wr_data;

    // Both halves in one array: address bit 7 selects the half.
    logic [23:0]  buf_mem [0:255];

    // VBLK edge detection. The armed flag only comes up once VBLK has been
    // seen low after reset. Without it, a VBLK that is already high when
    // reset releases would look like a fresh rising edge, because vblk_d
    // restarts at 0.
    always_ff @(posedge VCLKx4 or posedge RESET) begin
        if (RESET) begin
            vblk_d <= 1'b0;
            armed  <= 1'b0;
        end else begin
            vblk_d <= VBLK;
            if (!VBLK) begin
                armed <= 1'b1;
            end
        end
    end

    assign trigger = VBLK & ~vblk_d & armed;

    // Sequencer state, entry index and displayed-half register.
    always_ff @(posedge VCLKx4 or posedge RESET) begin
        if (RESET) begin
            state <= S_IDLE;
            idx   <= 7'd0;
            front <= 1'b0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            front <= front_nx;
        end
    end

    // Each source byte arrives one cycle after its read strobe. Bytes 0 and 1
    // are parked here. Byte 2 goes straight from SRC_D into the write.
    always_ff @(posedge VCLKx4 or posedge RESET) begin
        if (RESET) begin
            b0 <= 8'd0;
            b1 <= 8'd0;
        end else begin
            if (state == S_RD1) begin
                b0 <= SRC_D;
            end
            if (state == S_RD2) begin
                b1 <= SRC_D;
            end
        end
    end

    // Next-state and output decode. A trigger only matters in IDLE, so an
    // edge that arrives during a copy is dropped rather than queued. FREEZE
    // is looked at only in that same trigger cycle.
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        front_nx = front;
        SRC_A    = 9'd0;
        SRC_RD   = 1'b0;
        DONE     = 1'b0;
        wr_en    = 1'b0;
        case (state)
            S_IDLE: begin
                if (trigger && !FREEZE) begin
                    state_nx = S_RD0;
                    idx_nx   = 7'd0;
                end
            end
            S_RD0: begin
                SRC_A    = {2'd0, idx};
                SRC_RD   = 1'b1;
                state_nx = S_RD1;
            end
            S_RD1: begin
                SRC_A    = {2'd1, idx};
                SRC_RD   = 1'b1;
                state_nx = S_RD2;
            end
            S_RD2: begin
                SRC_A    = {2'd2, idx};
                SRC_RD   = 1'b1;
                state_nx = S_WR;
            end
            S_WR: begin
                wr_en = 1'b1;
                if (idx == 7'd127) begin
                    state_nx = S_SWAP;
                end else begin
                    idx_nx   = idx + 7'd1;
                    state_nx = S_RD0;
                end
            end
            S_SWAP: begin
                front_nx = ~front;
                DONE     = 1'b1;
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    assign BUSY  = (state != S_IDLE);
    assign FRONT = front;

    // Writes only ever go to the back half. The buffer is not cleared by
    // reset; a copy that reset interrupts simply leaves its half incomplete.
    assign wr_addr = {~front, idx};
    assign wr_data = {SRC_D, b1, b0};

    always_ff @(posedge VCLKx4) begin
        if (wr_en) begin
            buf_mem[wr_addr] <= wr_data;
        end
    end

    // Renderer port: asynchronous read of the front half only.
    assign SPRA_D = buf_mem[{front, SPRA_A}];

endmodule
